// File: rtl/microcode_sequencer_if.sv
// Bus between the microcode sequencer, its instruction register / step controls,
// the microcode ROM and the datapath.
interface microcode_sequencer_if #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3,
    parameter int CTRL_WIDTH   = 16
);
    logic [OPCODE_WIDTH-1:0]            i_opcode;
    logic                               i_mode;
    logic                               i_step;
    logic [CTRL_WIDTH-1:0]              i_rom_data;
    logic                               o_rom_re;
    logic [OPCODE_WIDTH+STEP_WIDTH-1:0] o_rom_addr;
    logic [CTRL_WIDTH-1:0]              o_ctrl;
    logic [STEP_WIDTH-1:0]              o_step;
    logic                               o_halted;

    modport slave (
        input  i_opcode, i_mode, i_step, i_rom_data,
        output o_rom_re, o_rom_addr, o_ctrl, o_step, o_halted
    );

    modport master (
        output i_opcode, i_mode, i_step, i_rom_data,
        input  o_rom_re, o_rom_addr, o_ctrl, o_step, o_halted
    );
endinterface

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: walks {opcode, step} through a zero-latency control ROM,
// free-running or single-stepped, until a halt word parks it until reset.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_RUN  | ROM read enabled, control word passed to datapath, step advances
//   ST_HALT | halt word seen; outputs idle, only reset leaves this state
module microcode_sequencer #(
    parameter int OPCODE_WIDTH = 4,
    parameter int STEP_WIDTH   = 3,
    parameter int CTRL_WIDTH   = 16,
    parameter int HLT_BIT      = 15,
    parameter int NXT_BIT      = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    microcode_sequencer_if.slave  bus
);
    typedef enum logic {ST_RUN, ST_HALT} state_t;

    localparam logic [STEP_WIDTH-1:0] STEP_MAX = {STEP_WIDTH{1'b1}};

    state_t                r_state;
    logic [STEP_WIDTH-1:0] r_step;
    logic                  r_step_q;

    state_t                w_state_nxt;
    logic [STEP_WIDTH-1:0] w_step_nxt;
    logic                  w_advance;

    // Single-step mode advances only on a rising edge of the manual step level.
    assign w_advance = bus.i_mode ? (bus.i_step & ~r_step_q) : 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_RUN;
            r_step   <= '0;
            r_step_q <= 1'b1;
        end else begin
            r_state  <= w_state_nxt;
            r_step   <= w_step_nxt;
            r_step_q <= bus.i_step;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_step_nxt     = r_step;
        bus.o_rom_re   = 1'b0;
        bus.o_ctrl     = '0;
        bus.o_rom_addr = {bus.i_opcode, r_step};
        bus.o_step     = r_step;
        bus.o_halted   = 1'b0;
        unique case (r_state)
            ST_RUN: begin
                bus.o_rom_re = 1'b1;
                bus.o_ctrl   = bus.i_rom_data;
                if (w_advance) begin
                    if (bus.i_rom_data[HLT_BIT]) begin
                        w_state_nxt = ST_HALT;
                    end else if (bus.i_rom_data[NXT_BIT]) begin
                        w_step_nxt = '0;
                    end else if (r_step == STEP_MAX) begin
                        w_step_nxt = '0;
                    end else begin
                        w_step_nxt = r_step + 1'b1;
                    end
                end
            end
            ST_HALT: begin
                bus.o_halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end
endmodule

// File: tb/tb_microcode_sequencer.sv
// Directed bench for microcode_sequencer with a behavioural ROM and an
// expected-result queue popped one edge after each step is driven.
module tb_microcode_sequencer;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] rom [0:127];

    typedef struct {
        logic [2:0]  step;
        logic        halted;
        logic        re;
        logic [6:0]  addr;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb[$];

    microcode_sequencer_if bus ();

    microcode_sequencer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    assign bus.i_rom_data = rom[bus.o_rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Push expectation for the state after the next edge, clock, then pop and compare.
    task automatic tick(input logic [2:0] exp_step, input logic exp_halted, input string tag);
        exp_t e;
        exp_t got;
        e.step   = exp_step;
        e.halted = exp_halted;
        e.re     = ~exp_halted;
        e.addr   = {bus.i_opcode, exp_step};
        e.ctrl   = exp_halted ? 16'h0000 : rom[{bus.i_opcode, exp_step}];
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".step"},   32'(bus.o_step),     32'(got.step));
        chk({tag, ".halted"}, 32'(bus.o_halted),   32'(got.halted));
        chk({tag, ".re"},     32'(bus.o_rom_re),   32'(got.re));
        chk({tag, ".addr"},   32'(bus.o_rom_addr), 32'(got.addr));
        chk({tag, ".ctrl"},   32'(bus.o_ctrl),     32'(got.ctrl));
    endtask

    initial begin
        // Payload words with halt and next bits clear, unique per address.
        for (int a = 0; a < 128; a++) rom[a] = 16'h0A00 | 16'(a << 1);
        rst          = 1'b1;
        bus.i_opcode = 4'h3;
        bus.i_mode   = 1'b0;
        bus.i_step   = 1'b0;
        @(negedge clk);
        tick(3'd0, 1'b0, "reset");
        rst = 1'b0;

        for (int k = 1; k <= 8; k++) tick(3'(k % 8), 1'b0, "freerun");

        rom[7'h1C] = rom[7'h1C] | 16'h0001;
        for (int k = 1; k <= 4; k++) tick(3'(k), 1'b0, "early_end");
        tick(3'd0, 1'b0, "early_end_wrap");

        bus.i_opcode = 4'hF;
        rom[7'h7A]   = rom[7'h7A] | 16'h8000;
        rst = 1'b1;
        tick(3'd0, 1'b0, "halt_rst");
        rst = 1'b0;
        tick(3'd1, 1'b0, "halt_s1");
        tick(3'd2, 1'b0, "halt_s2");
        tick(3'd2, 1'b1, "halt_enter");
        bus.i_mode = 1'b1;
        bus.i_step = 1'b1;
        tick(3'd2, 1'b1, "halt_steppulse");
        bus.i_step = 1'b0;
        tick(3'd2, 1'b1, "halt_steplow");
        bus.i_mode = 1'b0;
        tick(3'd2, 1'b1, "halt_modetoggle");
        rst = 1'b1;
        tick(3'd0, 1'b0, "halt_exit");
        rst = 1'b0;

        bus.i_opcode = 4'h1;
        bus.i_mode   = 1'b1;
        bus.i_step   = 1'b0;
        tick(3'd0, 1'b0, "ss_idle");
        for (int p = 1; p <= 3; p++) begin
            bus.i_step = 1'b1;
            tick(3'(p), 1'b0, "ss_rise");
            for (int h = 0; h < 4; h++) tick(3'(p), 1'b0, "ss_hold");
            bus.i_step = 1'b0;
            tick(3'(p), 1'b0, "ss_low");
        end
        bus.i_step = 1'b1;
        rst = 1'b1;
        tick(3'd0, 1'b0, "ss_rst_high");
        rst = 1'b0;
        for (int h = 0; h < 3; h++) tick(3'd0, 1'b0, "ss_after_rst");
        bus.i_mode = 1'b0;
        tick(3'd1, 1'b0, "mode_switch");
        bus.i_step = 1'b0;

        bus.i_opcode = 4'h5;
        rom[7'h2D]   = rom[7'h2D] | 16'h8001;
        rst = 1'b1;
        tick(3'd0, 1'b0, "prec_rst");
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) tick(3'(k), 1'b0, "prec_run");
        tick(3'd5, 1'b1, "prec_halt");
        rst = 1'b1;
        tick(3'd0, 1'b0, "prec_rst2");
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) tick(3'(k), 1'b0, "prec_run2");
        rst = 1'b1;
        tick(3'd0, 1'b0, "prec_rst_vs_hlt");
        rst = 1'b0;

        bus.i_opcode = 4'h1;
        for (int k = 1; k <= 3; k++) tick(3'(k), 1'b0, "opc_run");
        chk("opc_addr_before", 32'(bus.o_rom_addr), 32'h0B);
        bus.i_opcode = 4'h2;
        #1;
        chk("opc_addr_after", 32'(bus.o_rom_addr), 32'h13);
        chk("opc_step_hold",  32'(bus.o_step),     32'd3);
        tick(3'd4, 1'b0, "opc_continue");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/microcode_sequencer.md
MICROCODE_SEQUENCER -- requirements
Module: microcode_sequencer

Interface
REQ-001 Parameter OPCODE_WIDTH, default 4, SHALL be the width of the instruction opcode field.
REQ-002 Parameter STEP_WIDTH, default 3, SHALL be the width of the micro-step counter; the maximum step is 2**STEP_WIDTH-1.
REQ-003 Parameter CTRL_WIDTH, default 16, SHALL be the width of the control word.
REQ-004 Parameter HLT_BIT, default 15, SHALL be the control-word bit index meaning "halt".
REQ-005 Parameter NXT_BIT, default 0, SHALL be the control-word bit index meaning "end of instruction, restart at step 0".
REQ-006 The block SHALL have one clock, i_clk, and a synchronous active-high reset, i_rst.
REQ-007 Port i_clk SHALL be an input, 1 bit: the clock; all state updates happen on its rising edge.
REQ-008 Port i_rst SHALL be an input, 1 bit: synchronous active-high reset.
REQ-009 Port i_opcode SHALL be an input, OPCODE_WIDTH bits: the opcode from the instruction register.
REQ-010 Port i_mode SHALL be an input, 1 bit: 0 = free run, 1 = single step.
REQ-011 Port i_step SHALL be an input, 1 bit: the manual step level; it is used only when i_mode=1.
REQ-012 Port i_rom_data SHALL be an input, CTRL_WIDTH bits: the control word returned by the microcode ROM.
REQ-013 Port o_rom_re SHALL be an output, 1 bit: the ROM read enable.
REQ-014 Port o_rom_addr SHALL be an output, OPCODE_WIDTH+STEP_WIDTH bits: the ROM address.
REQ-015 Port o_ctrl SHALL be an output, CTRL_WIDTH bits: the control word driven to the datapath.
REQ-016 Port o_step SHALL be an output, STEP_WIDTH bits: the current micro-step.
REQ-017 Port o_halted SHALL be an output, 1 bit: high while the sequencer is in the HALT state.

Function
REQ-018 The block SHALL implement a two-state FSM with states RUN and HALT.
REQ-019 o_rom_addr SHALL equal {i_opcode, step}, with the opcode in the MSBs, combinationally.
REQ-020 o_rom_re SHALL be 1 in RUN and 0 in HALT.
REQ-021 o_ctrl SHALL equal i_rom_data in RUN and all-zero in HALT, combinationally; the ROM read therefore has zero-cycle latency to o_ctrl.
REQ-022 The advance enable SHALL be 1 every cycle when i_mode=0.
REQ-023 When i_mode=1, the advance enable SHALL be 1 only in a cycle where i_step=1 and the previous registered i_step sample, step_q, =0 (rising-edge detect).
REQ-024 step_q SHALL register i_step every cycle, regardless of mode.
REQ-025 In RUN with advance=1 and i_rom_data[HLT_BIT]=1, the FSM SHALL enter HALT on that edge, with step unchanged.
REQ-026 In RUN with advance=1, HLT bit=0 and NXT bit=1, step SHALL become 0.
REQ-027 In RUN with advance=1, HLT=0, NXT=0 and step=max, step SHALL wrap to 0.
REQ-028 In RUN with advance=1, HLT=0, NXT=0 and step<max, step SHALL increment by 1.
REQ-029 In RUN with advance=0, step and state SHALL hold.
REQ-030 When HLT and NXT are both set, HLT SHALL take precedence: the FSM goes to HALT and step does not change.
REQ-031 HALT SHALL be exited only by reset; i_step and i_mode SHALL have no effect in HALT.
REQ-032 A change of i_opcode mid-instruction SHALL change o_rom_addr immediately and SHALL NOT affect step.
REQ-033 A change of i_mode SHALL take effect in the same cycle for the advance-enable computation.
REQ-034 o_step SHALL equal the registered step; o_halted SHALL equal (state==HALT).

Reset
REQ-035 Reset SHALL have priority over all other events, including HLT, NXT and advance in the same cycle.
REQ-036 On reset, the sequencer SHALL set state=RUN, step=0 and step_q=1.
REQ-037 Because step_q resets to 1, an i_step held high through reset SHALL NOT produce an advance after reset.
REQ-038 After reset, o_halted=0, o_step=0, o_rom_re=1, and o_rom_addr={i_opcode, 0}.
REQ-039 A reset asserted mid-instruction or while in HALT SHALL return the block to step 0 in RUN on the next edge.

Verification
REQ-040 Free run: i_mode=0, opcode=4'h3, ROM words with HLT=0 and NXT=0 -> o_step sequence 0,1,...,7,0 on successive edges, and o_rom_addr 7'h18..7'h1F.
REQ-041 Early end: word at {3,4} has NXT=1 -> o_step sequence 0,1,2,3,4,0; o_ctrl equals the ROM word each cycle.
REQ-042 Halt: word at {4'hF,2} has bit15=1 -> o_halted=1 after the edge leaving step 2, o_step stays 2, o_ctrl=16'h0000, o_rom_re=0; i_step pulses and toggling i_mode produce no change; i_rst for one cycle -> o_halted=0, o_step=0.
REQ-043 Single step: i_mode=1, i_step held high for 5 cycles then low, repeated 3 times -> exactly 3 increments (o_step 0->1->2->3); i_step held high across reset -> no advance after reset.
REQ-044 Precedence: same word sets both HLT and NXT at step 5 -> HALT with o_step=5; i_rst asserted in the same cycle as HLT -> RUN, o_step=0.
REQ-045 Opcode change: opcode switched 4'h1->4'h2 at step 3 -> o_rom_addr goes 7'h0B->7'h13 in the same cycle, and o_step continues to 4.
